// File: rtl/floo_vc_credit_arbiter.sv
// Credit-gated round-robin arbiter sharing one flit link among NumVc virtual channels; FLOO_VC_ARB_WATCHDOG_EN adds per-VC stall watchdogs.
// Latency: one cycle from an input handshake to out_valid_o; one flit per cycle sustained while credits last.
// Backpressure: vc_ready_o drops while the output register is full and not draining, or when the winning VC has no far-end credit.
module floo_vc_credit_arbiter #(
    parameter int unsigned NumVc       = 2,
    parameter int unsigned DataWidth   = 64,
    parameter int unsigned NumCredits  = 3,
    parameter int unsigned StallCycles = 64,
    localparam int unsigned CntW       = $clog2(NumCredits + 1),
    localparam int unsigned IdxW       = $clog2(NumVc)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NumVc-1:0]          vc_valid_i,
    output logic [NumVc-1:0]          vc_ready_o,
    input  logic [NumVc*DataWidth-1:0] vc_data_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [DataWidth-1:0]      out_data_o,
    output logic [IdxW-1:0]           out_vc_o,
    input  logic [NumVc-1:0]          credit_ret_i,
    output logic [NumVc*CntW-1:0]     credits_o,
    output logic                      credit_err_o,
    output logic [NumVc-1:0]          stall_err_o
);

    if (NumVc < 2 || NumCredits < 1 || StallCycles < 1) begin : g_param_check
        $error("floo_vc_credit_arbiter: NumVc >= 2, NumCredits >= 1 and StallCycles >= 1 required");
    end

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [IdxW-1:0]        rr_q;
    logic [DataWidth-1:0]   data_q;
    logic [IdxW-1:0]        vc_q;
    logic [CntW-1:0]        credit_q [NumVc];
    logic [CntW-1:0]        credit_d [NumVc];
    logic                   credit_err_q;

    logic [NumVc-1:0]       eligible;
    logic [NumVc-1:0]       send;
    logic [NumVc-1:0]       overflow;
    logic [IdxW-1:0]        winner;
    logic                   any_elig;
    logic                   free;
    logic                   handshake;
    logic [DataWidth-1:0]   sel_data;

    assign out_valid_o  = (state_q == FULL);
    assign out_data_o   = data_q;
    assign out_vc_o     = vc_q;
    assign credit_err_o = credit_err_q;
    assign free         = !out_valid_o || out_ready_i;
    assign handshake    = !rst_i && free && any_elig;

    // Eligibility uses only the registered count, so a returned credit helps one cycle later.
    always_comb begin
        eligible = '0;
        for (int unsigned k = 0; k < NumVc; k++) begin
            eligible[k] = vc_valid_i[k] && (credit_q[k] != '0);
        end
    end

    always_comb begin
        logic [IdxW:0] sum;
        winner   = '0;
        any_elig = 1'b0;
        sum      = '0;
        for (int unsigned i = 0; i < NumVc; i++) begin
            sum = {1'b0, rr_q} + (IdxW + 1)'(i);
            if (sum >= (IdxW + 1)'(NumVc)) begin
                sum = sum - (IdxW + 1)'(NumVc);
            end
            if (!any_elig && eligible[sum[IdxW-1:0]]) begin
                any_elig = 1'b1;
                winner   = sum[IdxW-1:0];
            end
        end
    end

    // Data mux is off the ready path: the grant never looks at vc_data_i.
    always_comb begin
        sel_data = '0;
        for (int unsigned k = 0; k < NumVc; k++) begin
            if (winner == IdxW'(k)) begin
                sel_data = vc_data_i[k*DataWidth +: DataWidth];
            end
        end
    end

    always_comb begin
        vc_ready_o = '0;
        if (handshake) begin
            vc_ready_o[winner] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (handshake) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (!handshake && out_ready_i) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
            data_q  <= '0;
            vc_q    <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            if (handshake) begin
                data_q <= sel_data;
                vc_q   <= winner;
                rr_q   <= (winner == IdxW'(NumVc - 1)) ? '0 : winner + IdxW'(1);
            end
        end
    end

    always_comb begin
        send     = '0;
        overflow = '0;
        for (int unsigned k = 0; k < NumVc; k++) begin
            send[k]     = handshake && (winner == IdxW'(k));
            credit_d[k] = credit_q[k];
            if (send[k] && !credit_ret_i[k]) begin
                credit_d[k] = credit_q[k] - CntW'(1);
            end else if (credit_ret_i[k] && !send[k]) begin
                if (credit_q[k] == CntW'(NumCredits)) begin
                    overflow[k] = 1'b1;
                end else begin
                    credit_d[k] = credit_q[k] + CntW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned k = 0; k < NumVc; k++) begin
                credit_q[k] <= CntW'(NumCredits);
            end
            credit_err_q <= 1'b0;
        end else begin
            for (int unsigned k = 0; k < NumVc; k++) begin
                credit_q[k] <= credit_d[k];
            end
            credit_err_q <= |overflow;
        end
    end

    always_comb begin
        credits_o = '0;
        for (int unsigned k = 0; k < NumVc; k++) begin
            credits_o[k*CntW +: CntW] = credit_q[k];
        end
    end

`ifdef FLOO_VC_ARB_WATCHDOG_EN
    localparam int unsigned StallW = $clog2(StallCycles + 1);

    logic [StallW-1:0] stall_cnt_q [NumVc];
    logic [NumVc-1:0]  stall_err_q;

    // The flag sets on the same edge the counter arrives at StallCycles.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned k = 0; k < NumVc; k++) begin
                stall_cnt_q[k] <= '0;
            end
            stall_err_q <= '0;
        end else begin
            for (int unsigned k = 0; k < NumVc; k++) begin
                if (vc_valid_i[k] && (credit_q[k] == '0)) begin
                    if (stall_cnt_q[k] != StallW'(StallCycles)) begin
                        stall_cnt_q[k] <= stall_cnt_q[k] + StallW'(1);
                    end
                    if (stall_cnt_q[k] >= StallW'(StallCycles - 1)) begin
                        stall_err_q[k] <= 1'b1;
                    end
                end else begin
                    stall_cnt_q[k] <= '0;
                end
            end
        end
    end

    assign stall_err_o = stall_err_q;
`else
    assign stall_err_o = '0;
`endif

endmodule

// File: tb/tb_floo_vc_credit_arbiter.sv
// Directed bench for floo_vc_credit_arbiter with NumVc=2, NumCredits=3, StallCycles=8, 8-bit flits.
module tb_floo_vc_credit_arbiter;

    localparam int unsigned NumVc       = 2;
    localparam int unsigned DataWidth   = 8;
    localparam int unsigned NumCredits  = 3;
    localparam int unsigned StallCycles = 8;

`ifdef FLOO_VC_ARB_WATCHDOG_EN
    localparam logic [1:0] SW = 2'b01;
`else
    localparam logic [1:0] SW = 2'b00;
`endif

    logic        clk;
    logic        rst;
    logic [1:0]  vc_valid;
    logic [1:0]  vc_ready;
    logic [15:0] vc_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_vc;
    logic [1:0]  credit_ret;
    logic [3:0]  credits;
    logic        credit_err;
    logic [1:0]  stall_err;

    int checks = 0;
    int errors = 0;

    floo_vc_credit_arbiter #(
        .NumVc      (NumVc),
        .DataWidth  (DataWidth),
        .NumCredits (NumCredits),
        .StallCycles(StallCycles)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .vc_valid_i  (vc_valid),
        .vc_ready_o  (vc_ready),
        .vc_data_i   (vc_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_vc_o    (out_vc),
        .credit_ret_i(credit_ret),
        .credits_o   (credits),
        .credit_err_o(credit_err),
        .stall_err_o (stall_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] vld;
        logic       ordy;
        logic [1:0] ret;
        logic [7:0] d0;
        logic [1:0] rdy;
        logic       ov;
        logic       ovc;
        logic [7:0] odat;
        logic [3:0] cred;
        logic       cerr;
        logic [1:0] stall;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [1:0] vld, input logic ordy, input logic [1:0] ret,
                                input logic [7:0] d0, input logic [1:0] rdy, input logic ov,
                                input logic ovc, input logic [7:0] odat, input logic [3:0] cred,
                                input logic cerr, input logic [1:0] stall);
        vec_t v;
        v.vld = vld; v.ordy = ordy; v.ret = ret; v.d0 = d0;
        v.rdy = rdy; v.ov = ov; v.ovc = ovc; v.odat = odat;
        v.cred = cred; v.cerr = cerr; v.stall = stall;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        rst        = 1'b1;
        vc_valid   = 2'b11;
        out_ready  = 1'b1;
        credit_ret = 2'b00;
        vc_data    = 16'h2110;

        // Reset held two cycles; grants must stay low even with valid traffic.
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1 chk($sformatf("rst_ready[%0d]", c), 32'(vc_ready), 32'h0);
            @(posedge clk);
        end
        @(negedge clk);
        rst      = 1'b0;
        vc_valid = 2'b00;
        #1;
        chk("rst_credits",   32'(credits),    32'hF);
        chk("rst_out_valid", 32'(out_valid),  32'h0);
        chk("rst_out_data",  32'(out_data),   32'h0);
        chk("rst_ready",     32'(vc_ready),   32'h0);
        chk("rst_stall",     32'(stall_err),  32'h0);
        chk("rst_cerr",      32'(credit_err), 32'h0);
        @(posedge clk);

        // Alternating grants until credits run out.
        vecs.push_back(mk(2'b11, 1, 2'b00, 8'h10, 2'b01, 1, 0, 8'h10, 4'hE, 0, 2'b00));
        vecs.push_back(mk(2'b11, 1, 2'b00, 8'h10, 2'b10, 1, 1, 8'h21, 4'hA, 0, 2'b00));
        vecs.push_back(mk(2'b11, 1, 2'b00, 8'h10, 2'b01, 1, 0, 8'h10, 4'h9, 0, 2'b00));
        vecs.push_back(mk(2'b11, 1, 2'b00, 8'h10, 2'b10, 1, 1, 8'h21, 4'h5, 0, 2'b00));
        vecs.push_back(mk(2'b11, 1, 2'b00, 8'h10, 2'b01, 1, 0, 8'h10, 4'h4, 0, 2'b00));
        vecs.push_back(mk(2'b11, 1, 2'b00, 8'h10, 2'b10, 1, 1, 8'h21, 4'h0, 0, 2'b00));
        vecs.push_back(mk(2'b11, 1, 2'b00, 8'h10, 2'b00, 0, 1, 8'h21, 4'h0, 0, 2'b00));
        // Credit returned to VC0 cannot grant until the next cycle.
        vecs.push_back(mk(2'b11, 1, 2'b01, 8'h10, 2'b00, 0, 1, 8'h21, 4'h1, 0, 2'b00));
        vecs.push_back(mk(2'b11, 1, 2'b00, 8'h10, 2'b01, 1, 0, 8'h10, 4'h0, 0, 2'b00));
        // Refill one credit each, then load 0xA5 and stall the output.
        vecs.push_back(mk(2'b00, 1, 2'b11, 8'h10, 2'b00, 0, 0, 8'h10, 4'h5, 0, 2'b00));
        vecs.push_back(mk(2'b01, 0, 2'b00, 8'hA5, 2'b01, 1, 0, 8'hA5, 4'h4, 0, 2'b00));
        for (int i = 0; i < 5; i++) begin
            vecs.push_back(mk(2'b11, 0, 2'b00, 8'h10, 2'b00, 1, 0, 8'hA5, 4'h4, 0, 2'b00));
        end
        vecs.push_back(mk(2'b11, 1, 2'b00, 8'h10, 2'b10, 1, 1, 8'h21, 4'h0, 0, 2'b00));
        // VC1 send plus return in one cycle, then return at the ceiling.
        vecs.push_back(mk(2'b00, 1, 2'b10, 8'h10, 2'b00, 0, 1, 8'h21, 4'h4, 0, 2'b00));
        vecs.push_back(mk(2'b10, 1, 2'b10, 8'h10, 2'b10, 1, 1, 8'h21, 4'h4, 0, 2'b00));
        vecs.push_back(mk(2'b00, 1, 2'b10, 8'h10, 2'b00, 0, 1, 8'h21, 4'h8, 0, 2'b00));
        vecs.push_back(mk(2'b00, 1, 2'b10, 8'h10, 2'b00, 0, 1, 8'h21, 4'hC, 0, 2'b00));
        vecs.push_back(mk(2'b00, 1, 2'b10, 8'h10, 2'b00, 0, 1, 8'h21, 4'hC, 1, 2'b00));
        vecs.push_back(mk(2'b00, 1, 2'b00, 8'h10, 2'b00, 0, 1, 8'h21, 4'hC, 0, 2'b00));
        // VC0 stalled at zero credits for StallCycles cycles.
        for (int i = 0; i < 7; i++) begin
            vecs.push_back(mk(2'b01, 1, 2'b00, 8'h10, 2'b00, 0, 1, 8'h21, 4'hC, 0, 2'b00));
        end
        vecs.push_back(mk(2'b01, 1, 2'b00, 8'h10, 2'b00, 0, 1, 8'h21, 4'hC, 0, SW));
        vecs.push_back(mk(2'b01, 1, 2'b01, 8'h10, 2'b00, 0, 1, 8'h21, 4'hD, 0, SW));
        vecs.push_back(mk(2'b00, 1, 2'b00, 8'h10, 2'b00, 0, 1, 8'h21, 4'hD, 0, SW));

        foreach (vecs[i]) begin
            @(negedge clk);
            vc_valid   = vecs[i].vld;
            out_ready  = vecs[i].ordy;
            credit_ret = vecs[i].ret;
            vc_data    = {8'h21, vecs[i].d0};
            #1 chk($sformatf("vc_ready[%0d]", i), 32'(vc_ready), 32'(vecs[i].rdy));
            @(posedge clk);
            #1;
            chk($sformatf("out_valid[%0d]", i), 32'(out_valid), 32'(vecs[i].ov));
            chk($sformatf("out_vc[%0d]", i),    32'(out_vc),    32'(vecs[i].ovc));
            chk($sformatf("out_data[%0d]", i),  32'(out_data),  32'(vecs[i].odat));
            chk($sformatf("credits[%0d]", i),   32'(credits),   32'(vecs[i].cred));
            chk($sformatf("credit_err[%0d]", i), 32'(credit_err), 32'(vecs[i].cerr));
            chk($sformatf("stall_err[%0d]", i), 32'(stall_err), 32'(vecs[i].stall));
        end

        // Reset while a flit sits in the output register.
        @(negedge clk);
        vc_valid   = 2'b01;
        out_ready  = 1'b0;
        credit_ret = 2'b00;
        vc_data    = 16'h215A;
        #1 chk("mid_load_ready", 32'(vc_ready), 32'h1);
        @(posedge clk);
        #1;
        chk("mid_load_valid", 32'(out_valid), 32'h1);
        chk("mid_load_data",  32'(out_data),  32'h5A);
        @(negedge clk);
        rst      = 1'b1;
        vc_valid = 2'b11;
        #1 chk("mid_rst_ready", 32'(vc_ready), 32'h0);
        @(posedge clk);
        #1;
        chk("mid_rst_valid",   32'(out_valid),  32'h0);
        chk("mid_rst_data",    32'(out_data),   32'h0);
        chk("mid_rst_vc",      32'(out_vc),     32'h0);
        chk("mid_rst_credits", 32'(credits),    32'hF);
        chk("mid_rst_cerr",    32'(credit_err), 32'h0);
        chk("mid_rst_stall",   32'(stall_err),  32'h0);
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        #1 chk("post_rst_ptr_ready", 32'(vc_ready), 32'h1);
        @(posedge clk);
        #1;
        chk("post_rst_vc",      32'(out_vc),  32'h0);
        chk("post_rst_credits", 32'(credits), 32'hE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
